bf_stream_host: RTL



---
 rtl/bf_stream_host.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bf_stream_host.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bf_stream_host : host valid/ready streams <-> bf_machine strobe byte port.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module bf_stream_host #(
  parameter int                   WORD_SIZE = 8,
  parameter int                   IN_DEPTH  = 16,
  parameter int                   OUT_DEPTH = 16,
  parameter logic [WORD_SIZE-1:0] EOF_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WORD_SIZE-1:0]             host_in_data,
  input  logic                             host_in_valid,
  output logic                             host_in_ready,
  output logic [WORD_SIZE-1:0]             machine_input,
  input  logic                             machine_input_ready,
  input  logic [WORD_SIZE-1:0]             machine_output,
  input  logic                             machine_output_valid,
  output logic [WORD_SIZE-1:0]             host_out_data,
  output logic                             host_out_valid,
  input  logic                             host_out_ready,
  output logic [$clog2(IN_DEPTH+1)-1:0]    in_level,
  output logic [$clog2(OUT_DEPTH+1)-1:0]   out_level,
  output logic                             underflow,
  output logic                             overflow,
  input  logic                             status_clr
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int IN_LW  = $clog2(IN_DEPTH + 1);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int OUT_LW = $clog2(OUT_DEPTH + 1);
  localparam logic [IN_LW-1:0]  IN_FULL  = IN_LW'(IN_DEPTH);
  localparam logic [OUT_LW-1:0] OUT_FULL = OUT_LW'(OUT_DEPTH);

  logic [WORD_SIZE-1:0] in_mem_q  [IN_DEPTH];
  logic [WORD_SIZE-1:0] out_mem_q [OUT_DEPTH];

  logic [IN_AW-1:0]  in_rd_q, in_rd_d, in_wr_q, in_wr_d, in_rd_nxt;
  logic [IN_LW-1:0]  in_lvl_q, in_lvl_d;
  logic [OUT_AW-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
  logic [OUT_LW-1:0] out_lvl_q, out_lvl_d;
  logic              uf_q, uf_d, ov_q, ov_d;

  logic in_push, in_pop, out_push, out_pop, uf_set, ov_set;

  // Input path: readiness comes from registered level only.
  assign host_in_ready = (in_lvl_q != IN_FULL);
  assign in_push       = host_in_valid && host_in_ready;
  assign in_pop        = machine_input_ready && (in_lvl_q != '0);
  assign uf_set        = machine_input_ready && (in_lvl_q == '0);
  assign in_rd_nxt     = in_rd_q + IN_AW'(1);

  // The core's strobe trails its read by a cycle, so during the strobe the
  // byte it will read next is the one behind the head.
  always_comb begin
    machine_input = EOF_VALUE;
    if (machine_input_ready) begin
      if (in_lvl_q >= IN_LW'(2)) machine_input = in_mem_q[in_rd_nxt];
    end else begin
      if (in_lvl_q != '0) machine_input = in_mem_q[in_rd_q];
    end
  end

  // Output path: a full FIFO still accepts a byte when the head leaves.
  assign host_out_valid = (out_lvl_q != '0);
  assign host_out_data  = out_mem_q[out_rd_q];
  assign out_pop        = host_out_valid && host_out_ready;
  assign out_push       = machine_output_valid && ((out_lvl_q != OUT_FULL) || out_pop);
  assign ov_set         = machine_output_valid && (out_lvl_q == OUT_FULL) && !out_pop;

  always_comb begin
    in_rd_d   = in_rd_q;
    in_wr_d   = in_wr_q;
    in_lvl_d  = in_lvl_q;
    out_rd_d  = out_rd_q;
    out_wr_d  = out_wr_q;
    out_lvl_d = out_lvl_q;
    uf_d      = uf_q;
    ov_d      = ov_q;

    if (in_push) in_wr_d = in_wr_q + IN_AW'(1);
    if (in_pop)  in_rd_d = in_rd_nxt;
    case ({in_push, in_pop})
      2'b10:   in_lvl_d = in_lvl_q + IN_LW'(1);
      2'b01:   in_lvl_d = in_lvl_q - IN_LW'(1);
      default: in_lvl_d = in_lvl_q;
    endcase

    if (out_push) out_wr_d = out_wr_q + OUT_AW'(1);
    if (out_pop)  out_rd_d = out_rd_q + OUT_AW'(1);
    case ({out_push, out_pop})
      2'b10:   out_lvl_d = out_lvl_q + OUT_LW'(1);
      2'b01:   out_lvl_d = out_lvl_q - OUT_LW'(1);
      default: out_lvl_d = out_lvl_q;
    endcase

    // A new event wins over a clear arriving in the same cycle.
    if (uf_set)          uf_d = 1'b1;
    else if (status_clr) uf_d = 1'b0;
    if (ov_set)          ov_d = 1'b1;
    else if (status_clr) ov_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_rd_q   <= '0;
      in_wr_q   <= '0;
      in_lvl_q  <= '0;
      out_rd_q  <= '0;
      out_wr_q  <= '0;
      out_lvl_q <= '0;
      uf_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      in_rd_q   <= in_rd_d;
      in_wr_q   <= in_wr_d;
      in_lvl_q  <= in_lvl_d;
      out_rd_q  <= out_rd_d;
      out_wr_q  <= out_wr_d;
      out_lvl_q <= out_lvl_d;
      uf_q      <= uf_d;
      ov_q      <= ov_d;
    end
  end

  // Storage is left uninitialised; pointers alone define valid entries.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wr_q]   <= host_in_data;
    if (out_push) out_mem_q[out_wr_q] <= machine_output;
  end

  assign in_level  = in_lvl_q;
  assign out_level = out_lvl_q;
  assign underflow = uf_q;
  assign overflow  = ov_q;

endmodule
`default_nettype wire
